// File: rtl/or32_bit_decomposer.sv
// Splits a 32-bit word into a stream of one-hot beats, one per set bit (one zero beat for 0).
// Define OR32_DECOMP_MSB_FIRST_EN to scan from the highest set bit down instead of LSB first.
module or32_bit_decomposer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] in_word,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_onehot,
    output logic [4:0]  out_index,
    output logic        out_last,
    output logic [5:0]  bit_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_d;
    logic [31:0] rem, rem_d;
    logic        upd;
    logic [31:0] oh_d;
    logic [4:0]  idx_d;
    logic        last_d;

    function automatic logic [31:0] pick(input logic [31:0] w);
`ifdef OR32_DECOMP_MSB_FIRST_EN
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (w[i]) r = 32'd1 << i;
        return r;
`else
        return w & (~w + 32'd1);
`endif
    endfunction

    function automatic logic [4:0] enc(input logic [31:0] oh);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) r = 5'(i);
        return r;
    endfunction

    function automatic logic [5:0] popcnt(input logic [31:0] w);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++)
            c = c + {5'd0, w[i]};
        return c;
    endfunction

    always_comb begin
        state_d = state;
        rem_d   = rem;
        upd     = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                rem_d   = in_word;
                state_d = EMIT;
                upd     = 1'b1;
            end
            EMIT: if (out_ready) begin
                rem_d = rem & ~out_onehot;
                upd   = 1'b1;
                if (out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Next beat is derived from the post-update remainder so outputs can be registered.
        oh_d   = pick(rem_d);
        idx_d  = enc(oh_d);
        last_d = ((rem_d & (rem_d - 32'd1)) == 32'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            bit_count  <= '0;
        end else begin
            state     <= state_d;
            rem       <= rem_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == EMIT);
            if (upd) begin
                out_onehot <= (state_d == EMIT) ? oh_d   : 32'd0;
                out_index  <= (state_d == EMIT) ? idx_d  : 5'd0;
                out_last   <= (state_d == EMIT) ? last_d : 1'b0;
            end
            if (state == IDLE && in_valid)
                bit_count <= popcnt(in_word);
        end
    end

endmodule

// File: tb/tb_or32_bit_decomposer.sv
// Table-driven bench for or32_bit_decomposer with a beat scoreboard and hand-written corner sequences.
module tb_or32_bit_decomposer;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready;
    logic [31:0] in_word;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_onehot;
    logic [4:0]  out_index;
    logic [5:0]  bit_count;

    or32_bit_decomposer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_onehot(out_onehot), .out_index(out_index), .out_last(out_last),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] oh;
        logic [4:0]  idx;
        logic        last;
        logic [5:0]  bc;
    } beat_t;

    typedef struct {
        logic [31:0] word;
        int          mode;      // 0 always ready, 1 toggle, 2 random
        logic        junk;      // hold in_valid high with a stray word mid-stream
        int          exp_beats;
        logic [5:0]  exp_bc;
    } vec_t;

    beat_t sbq[$];
    int    npass = 0;
    int    ntot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic push_model(input logic [31:0] w);
        beat_t b;
        int    cnt;
        int    pos;
        int    first;
        cnt = 0;
        for (int i = 0; i < 32; i++) if (w[i]) cnt++;
        if (w == 32'd0) begin
            b.oh = '0; b.idx = '0; b.last = 1'b1; b.bc = '0;
            sbq.push_back(b);
        end else begin
            first = sbq.size();
            for (int j = 0; j < 32; j++) begin
`ifdef OR32_DECOMP_MSB_FIRST_EN
                pos = 31 - j;
`else
                pos = j;
`endif
                if (w[pos]) begin
                    b.oh = 32'd1 << pos; b.idx = 5'(pos); b.last = 1'b0; b.bc = 6'(cnt);
                    sbq.push_back(b);
                end
            end
            if (sbq.size() > first) sbq[sbq.size()-1].last = 1'b1;
        end
    endtask

    // Called at a falling edge; the load lands on the following rising edge.
    task automatic do_load(input logic [31:0] w, input logic hold);
        in_valid = 1'b1;
        in_word  = w;
        chk("load_ready", 32'(in_ready), 32'd1);
        push_model(w);
        @(negedge clk);
        in_valid = hold;
        chk("first_beat_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input int mode, input int maxb, input logic jv, input logic [31:0] jw,
                         input logic keep, output int nb, output logic [31:0] acc);
        logic        done, have_prev;
        logic [31:0] p_oh;
        logic [4:0]  p_idx;
        logic        p_last;
        beat_t       e;
        nb = 0; acc = '0; done = 1'b0; have_prev = 1'b0;
        p_oh = '0; p_idx = '0; p_last = 1'b0;
        for (int c = 0; c < 400 && !done && nb < maxb; c++) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            in_valid  = jv;
            in_word   = jw;
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("busy_ready", 32'(in_ready), 32'd0);
            if (have_prev) begin
                chk("stall_onehot", out_onehot, p_oh);
                chk("stall_index", 32'(out_index), 32'(p_idx));
                chk("stall_last", 32'(out_last), 32'(p_last));
            end
            if (out_ready && out_valid) begin
                if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("beat_onehot", out_onehot, e.oh);
                    chk("beat_index", 32'(out_index), 32'(e.idx));
                    chk("beat_last", 32'(out_last), 32'(e.last));
                    chk("beat_count", 32'(bit_count), 32'(e.bc));
                end
                acc = acc | out_onehot;
                nb++;
                if (out_last) done = 1'b1;
                have_prev = 1'b0;
            end else begin
                have_prev = 1'b1;
                p_oh = out_onehot; p_idx = out_index; p_last = out_last;
            end
            @(negedge clk);
        end
        if (!done && nb < maxb) chk("drain_timeout", 32'd0, 32'd1);
        if (done) begin
            in_valid = keep;
            in_word  = jw;
            chk("idle_valid", 32'(out_valid), 32'd0);
            chk("idle_ready", 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t        vt[5];
        int          nb;
        logic [31:0] acc;

        vt[0] = '{32'h0000A5A5, 0, 1'b0, 8, 6'd8};
        vt[1] = '{32'h00000000, 0, 1'b0, 1, 6'd0};
        vt[2] = '{32'hFFFFFFFF, 1, 1'b1, 32, 6'd32};
        vt[3] = '{32'h00005A5A, 2, 1'b0, 8, 6'd8};
        vt[4] = '{32'h80000001, 2, 1'b1, 2, 6'd2};

        rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_onehot", out_onehot, 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            do_load(vt[v].word, vt[v].junk);
            drain(vt[v].mode, 99, vt[v].junk, 32'h00000001, 1'b0, nb, acc);
            chk("vec_beats", 32'(nb), 32'(vt[v].exp_beats));
            chk("vec_or", acc, vt[v].word);
            chk("vec_bit_count", 32'(bit_count), 32'(vt[v].exp_bc));
            chk("vec_sb_empty", 32'(sbq.size()), 32'd0);
            @(negedge clk);
        end

        // Reset in the middle of a stream
        do_load(32'h0000A5A5, 1'b0);
        drain(0, 3, 1'b0, 32'd0, 1'b0, nb, acc);
        chk("pre_rst_beats", 32'(nb), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_bit_count", 32'(bit_count), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(32'h00000001, 1'b0);
        drain(0, 99, 1'b0, 32'd0, 1'b0, nb, acc);
        chk("postrst_beats", 32'(nb), 32'd1);
        chk("postrst_or", acc, 32'h00000001);
        @(negedge clk);

        // Back-to-back words with in_valid held high
        do_load(32'h80000000, 1'b1);
        drain(0, 99, 1'b1, 32'h00000003, 1'b1, nb, acc);
        chk("b2b_first_beats", 32'(nb), 32'd1);
        push_model(32'h00000003);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_valid", 32'(out_valid), 32'd1);
        drain(0, 99, 1'b0, 32'd0, 1'b0, nb, acc);
        chk("b2b_second_beats", 32'(nb), 32'd2);
        chk("b2b_second_or", acc, 32'h00000003);
        chk("final_sb_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/or32_bit_decomposer.md
# or32_bit_decomposer

Sequential inverse of the 32-bit bitwise OR unit. It accepts one 32-bit word and emits its set bits as a stream of one-hot 32-bit words, one per accepted output beat. OR-ing all emitted beats together reconstructs the input word exactly. It sits downstream of the lab's logic units and feeds bit-serial consumers, such as register-mask walkers and interrupt-source scanners.

## Interface
- No parameters. Width is fixed at 32.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `in_word` is valid.
- `in_word` input 32: word to decompose.
- `in_ready` output 1: block can accept a word.
- `out_valid` output 1: the current beat is valid.
- `out_ready` input 1: the consumer accepts the beat.
- `out_onehot` output 32: the current set bit (one-hot), or all-zero for the zero-word beat.
- `out_index` output 5: bit position of `out_onehot`, or 0 for the zero-word beat.
- `out_last` output 1: the current beat is the final beat of the word.
- `bit_count` output 6: popcount of the most recently loaded word, held until the next load.

## Operation
- States: IDLE and EMIT. All outputs are registered.
- **IDLE**
  - `in_ready` = 1 and `out_valid` = 0.
  - On `in_valid` && `in_ready`: latch `in_word` into the working register `rem` and latch its popcount into `bit_count`.
  - Then go to EMIT.
- **EMIT**
  - `in_ready` = 0.
  - `out_onehot` is the lowest set bit of `rem`, isolated (`rem & -rem`).
  - `out_index` is its position.
  - `out_last` = 1 when `rem` has exactly one bit set.
- **Handshake.** A beat transfers on `out_valid` && `out_ready`.
  - On a transfer, the emitted bit is cleared from `rem`.
  - If `out_last` was 1, go to IDLE; otherwise the next beat is presented the following cycle.
- **Backpressure.** While `out_valid` = 1 and `out_ready` = 0, `out_onehot`, `out_index` and `out_last` hold stable.
- **Zero word.**
  - Exactly one beat is emitted: `out_onehot` = 0, `out_index` = 0, `out_last` = 1, `bit_count` = 0.
  - The block then returns to IDLE.
- **Inputs while busy.** `in_valid` is ignored while in EMIT. The producer holds its word until `in_ready` is high.
- **Arithmetic.**
  - `bit_count` ranges 0..32 (6 bits, no overflow).
  - `out_index` ranges 0..31.
  - Beats per word = max(`bit_count`, 1).
- **Reset.**
  - `rst_n` low at any time, including mid-EMIT, returns the block to IDLE immediately.
  - Reset values: `in_ready` = 1, `out_valid` = 0, `out_onehot` = 0, `out_index` = 0, `out_last` = 0, `bit_count` = 0, `rem` = 0.
  - The partially emitted word is discarded.

## Timing
- **Load to first beat.** Load is accepted at edge N. `out_valid` = 1 with the first beat from edge N+1.
- **Throughput.** One beat per cycle while `out_ready` = 1.
- **Return to IDLE.** The last beat transfers at edge M. `out_valid` = 0 and `in_ready` = 1 from edge M+1. The earliest next load is at edge M+1.
- **Word period.** Minimum period per word = beats + 1 cycles.
- **No overlap.** A new load never occurs in the same cycle as a final-beat transfer.
- **Reset release.** After `rst_n` deasserts, the first load can occur at the first rising edge with `in_valid` = 1.

## Configuration
- `OR32_DECOMP_MSB_FIRST_EN`
  - **Defined:** scan from the highest set bit downward. `out_onehot` is the highest set bit of `rem`, and `out_last` marks the lowest set bit.
  - **Undefined (default):** scan LSB first, as described above.
- All other behaviour, including the zero-word beat, `bit_count`, timing and reset, is identical in both builds.

## Test plan
- **LSB-first sequence.** Load `32'h0000A5A5` with `out_ready` = 1.
  - Required: 8 consecutive beats with `out_index` 0, 2, 5, 7, 8, 10, 13, 15.
  - `out_last` is asserted only on index 15. `bit_count` = 8.
  - The OR of all `out_onehot` values equals `32'h0000A5A5`.
- **Zero word.** Load `32'h00000000`.
  - Required: exactly one beat with `out_onehot` = 0, `out_index` = 0, `out_last` = 1 and `bit_count` = 0.
  - `in_ready` = 1 the next cycle.
- **Full word with backpressure.** Load `32'hFFFFFFFF` and toggle `out_ready` 1,0,1,0…
  - Required: 32 beats with indices 0..31 in order, `bit_count` = 32.
  - Beat outputs are stable during stalls. `in_valid` asserted mid-stream is not accepted.
- **Reset mid-stream.** Load `32'h0000A5A5`, accept 3 beats, then pulse `rst_n` low.
  - Required: `out_valid` = 0 and `in_ready` = 1 immediately.
  - A subsequent load of `32'h00000001` yields a single beat: index 0, `out_last` = 1.
- **MSB-first build.** With `OR32_DECOMP_MSB_FIRST_EN` defined, load `32'h00005A5A`.
  - Required: indices 14, 12, 11, 9, 6, 4, 3, 1, with `out_last` on index 1 and `bit_count` = 8.
- **Back-to-back words.** Load `32'h80000000` and then `32'h00000003` with `in_valid` held high.
  - Required: index 31 (last), then one IDLE cycle, then indices 0 and 1 (last on 1).
